// File: rtl/ysyx_23060025_rd_arbiter_if.sv
// rtl/ysyx_23060025_rd_arbiter_if.sv - requester and AXI read-channel bundle for the read arbiter
interface ysyx_23060025_rd_arbiter_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  // IFU requester side
  logic                ifu_req_i;
  logic [ADDR_LEN-1:0] ifu_addr_i;
  logic                ifu_gnt_o;
  logic                ifu_rvalid_o;
  // LSU requester side
  logic                lsu_req_i;
  logic [ADDR_LEN-1:0] lsu_addr_i;
  logic [2:0]          lsu_size_i;
  logic                lsu_gnt_o;
  logic                lsu_rvalid_o;
  // shared response toward both requesters
  logic [DATA_LEN-1:0] rsp_data_o;
  logic [1:0]          rsp_resp_o;
  logic                rsp_last_o;
  // AXI4 AR channel
  logic                axi_arvalid_o;
  logic                axi_arready_i;
  logic [ADDR_LEN-1:0] axi_araddr_o;
  logic [3:0]          axi_arid_o;
  logic [7:0]          axi_arlen_o;
  logic [2:0]          axi_arsize_o;
  logic [1:0]          axi_arburst_o;
  // AXI4 R channel
  logic                axi_rvalid_i;
  logic                axi_rready_o;
  logic [DATA_LEN-1:0] axi_rdata_i;
  logic [1:0]          axi_rresp_i;
  logic                axi_rlast_i;
  logic [3:0]          axi_rid_i;

  // arbiter view: drives grants, responses and the AXI master outputs
  modport master (
    input  ifu_req_i, ifu_addr_i, lsu_req_i, lsu_addr_i, lsu_size_i,
    input  axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rid_i,
    output ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o,
    output rsp_data_o, rsp_resp_o, rsp_last_o,
    output axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
    output axi_rready_o
  );

  // environment view: requesters plus the downstream AXI slave
  modport slave (
    output ifu_req_i, ifu_addr_i, lsu_req_i, lsu_addr_i, lsu_size_i,
    output axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rid_i,
    input  ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o,
    input  rsp_data_o, rsp_resp_o, rsp_last_o,
    input  axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
    input  axi_rready_o
  );
endinterface

// File: rtl/ysyx_23060025_rd_arbiter.sv
// rtl/ysyx_23060025_rd_arbiter.sv - single-outstanding IFU/LSU read arbiter with starvation guard and R framing checks
module ysyx_23060025_rd_arbiter #(
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  ysyx_23060025_rd_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  localparam logic [7:0] IFU_LEN    = 8'(BURST_LEN - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [1:0]          r_state;
  logic                r_owner;   // 0 = IFU, 1 = LSU; doubles as the AXI ID
  logic [ADDR_LEN-1:0] r_addr;
  logic [2:0]          r_size;
  logic [7:0]          r_len;
  logic [3:0]          r_beat;    // index of the next expected beat
  logic                r_over;    // a non-last beat already hit the final index
  logic [7:0]          r_starve;

  logic       w_idle;
  logic       w_any_req;
  logic       w_pick_ifu;
  logic       w_pick_lsu;
  logic       w_grant;
  logic       w_in_ar;
  logic       w_beat;
  logic [7:0] w_beat8;
  logic       w_id_err;
  logic       w_len_err;

  // IFU wins only when LSU is idle or IFU has waited through STARVE_MAX LSU grants
  always_comb begin
    w_idle     = (r_state == S_IDLE) && !reset;
    w_any_req  = bus.ifu_req_i || bus.lsu_req_i;
    w_pick_ifu = bus.ifu_req_i && (!bus.lsu_req_i || (r_starve == STARVE_LIM));
    w_pick_lsu = bus.lsu_req_i && !w_pick_ifu;
    w_grant    = w_idle && w_any_req;
    w_in_ar    = (r_state == S_AR);
    w_beat     = (r_state == S_R) && bus.axi_rvalid_i;
    w_beat8    = {4'b0000, r_beat};
    w_id_err   = (bus.axi_rid_i != {3'b000, r_owner});
    w_len_err  = r_over || (w_beat8 > r_len) || (bus.axi_rlast_i && (w_beat8 != r_len));
  end

  // grant pulses, AR fields and response pass-through; everything reads zero outside its phase
  always_comb begin
    bus.ifu_gnt_o     = w_idle && w_pick_ifu;
    bus.lsu_gnt_o     = w_idle && w_pick_lsu;
    bus.axi_arvalid_o = w_in_ar;
    bus.axi_araddr_o  = w_in_ar ? r_addr : '0;
    bus.axi_arid_o    = w_in_ar ? {3'b000, r_owner} : 4'd0;
    bus.axi_arlen_o   = w_in_ar ? r_len : 8'd0;
    bus.axi_arsize_o  = w_in_ar ? r_size : 3'd0;
    bus.axi_arburst_o = w_in_ar ? 2'b01 : 2'b00;
    bus.axi_rready_o  = (r_state == S_R);
    bus.ifu_rvalid_o  = w_beat && !r_owner;
    bus.lsu_rvalid_o  = w_beat && r_owner;
    bus.rsp_data_o    = w_beat ? bus.axi_rdata_i : '0;
    bus.rsp_last_o    = w_beat && bus.axi_rlast_i;
    bus.rsp_resp_o    = 2'b00;
    if (w_beat) begin
      bus.rsp_resp_o = (w_id_err || w_len_err) ? 2'b10 : bus.axi_rresp_i;
    end
  end

  // IDLE -> AR -> R -> IDLE; only rvalid with rlast closes a transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_grant) r_state <= S_AR;
        S_AR:    if (bus.axi_arready_i) r_state <= S_R;
        S_R:     if (bus.axi_rvalid_i && bus.axi_rlast_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // capture the winner's request fields at grant so AR stays stable while waiting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_size  <= 3'd0;
      r_len   <= 8'd0;
    end else if (w_grant) begin
      r_owner <= w_pick_lsu;
      r_addr  <= w_pick_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
      r_size  <= w_pick_lsu ? bus.lsu_size_i : 3'b010;
      r_len   <= w_pick_lsu ? 8'd0 : IFU_LEN;
    end
  end

  // beat index for framing checks, restarted at every grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_beat <= 4'd0;
      r_over <= 1'b0;
    end else if (w_grant) begin
      r_beat <= 4'd0;
      r_over <= 1'b0;
    end else if (w_beat) begin
      if (r_beat != 4'd15) r_beat <= r_beat + 4'd1;
      if ((w_beat8 == r_len) && !bus.axi_rlast_i) r_over <= 1'b1;
    end
  end

  // count LSU wins that left the IFU waiting; any IFU grant clears the debt
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= 8'd0;
    end else if (w_grant) begin
      if (w_pick_ifu) begin
        r_starve <= 8'd0;
      end else if (bus.ifu_req_i && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// tb/tb_ysyx_23060025_rd_arbiter.sv - directed self-checking bench for the IFU/LSU read arbiter
module tb_ysyx_23060025_rd_arbiter;

  localparam int BURST_LEN = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ysyx_23060025_rd_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  ysyx_23060025_rd_arbiter #(
    .ADDR_LEN(32), .DATA_LEN(32), .BURST_LEN(BURST_LEN), .STARVE_MAX(4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // entered in the IDLE cycle with requests already settled
  task automatic txn(input bit el, input int ar_dly, input int last_at, input logic [3:0] rid,
                     input bit keep, input logic [31:0] eaddr, input logic [2:0] esize,
                     input logic [31:0] dbase);
    logic [7:0] elen;
    bit         err;
    elen = el ? 8'd0 : 8'(BURST_LEN - 1);
    check("ifu_gnt", {31'b0, bus.ifu_gnt_o}, {31'b0, !el});
    check("lsu_gnt", {31'b0, bus.lsu_gnt_o}, {31'b0, el});
    step();
    if (!keep) begin
      if (el) bus.lsu_req_i = 1'b0;
      else    bus.ifu_req_i = 1'b0;
    end
    for (int k = 0; k <= ar_dly; k++) begin
      bus.axi_arready_i = (k == ar_dly);
      #1;
      check("arvalid", {31'b0, bus.axi_arvalid_o}, 32'd1);
      check("araddr", bus.axi_araddr_o, eaddr);
      check("arlen", {24'b0, bus.axi_arlen_o}, {24'b0, elen});
      check("arsize", {29'b0, bus.axi_arsize_o}, {29'b0, esize});
      check("arid", {28'b0, bus.axi_arid_o}, {31'b0, el});
      check("arburst", {30'b0, bus.axi_arburst_o}, 32'd1);
      check("gnt_in_ar", {30'b0, bus.ifu_gnt_o, bus.lsu_gnt_o}, 32'd0);
      step();
    end
    bus.axi_arready_i = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      bus.axi_rvalid_i = 1'b1;
      bus.axi_rdata_i  = dbase + 32'(b);
      bus.axi_rlast_i  = (b == last_at);
      bus.axi_rid_i    = rid;
      bus.axi_rresp_i  = 2'b00;
      #1;
      err = (rid != {3'b000, el}) || (b > int'(elen)) || ((b == last_at) && (b != int'(elen)));
      check("rready", {31'b0, bus.axi_rready_o}, 32'd1);
      check("ifu_rvalid", {31'b0, bus.ifu_rvalid_o}, {31'b0, !el});
      check("lsu_rvalid", {31'b0, bus.lsu_rvalid_o}, {31'b0, el});
      check("rsp_data", bus.rsp_data_o, dbase + 32'(b));
      check("rsp_resp", {30'b0, bus.rsp_resp_o}, err ? 32'd2 : 32'd0);
      check("rsp_last", {31'b0, bus.rsp_last_o}, (b == last_at) ? 32'd1 : 32'd0);
      step();
    end
    bus.axi_rvalid_i = 1'b0;
    bus.axi_rlast_i  = 1'b0;
    #1;
    check("idle_rready", {31'b0, bus.axi_rready_o}, 32'd0);
    check("idle_arvalid", {31'b0, bus.axi_arvalid_o}, 32'd0);
  endtask

  logic order [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.ifu_req_i = 1'b0; bus.ifu_addr_i = 32'd0;
    bus.lsu_req_i = 1'b0; bus.lsu_addr_i = 32'd0; bus.lsu_size_i = 3'd0;
    bus.axi_arready_i = 1'b0; bus.axi_rvalid_i = 1'b0; bus.axi_rdata_i = 32'd0;
    bus.axi_rresp_i = 2'b00; bus.axi_rlast_i = 1'b0; bus.axi_rid_i = 4'd0;
    step();
    step();
    bus.lsu_req_i = 1'b1;
    #1;
    check("rst_lsu_gnt", {31'b0, bus.lsu_gnt_o}, 32'd0);
    check("rst_arvalid", {31'b0, bus.axi_arvalid_o}, 32'd0);
    check("rst_rready", {31'b0, bus.axi_rready_o}, 32'd0);
    check("rst_araddr", bus.axi_araddr_o, 32'd0);
    bus.lsu_req_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    // IFU-only burst refill
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h3000_0010;
    #1;
    txn(1'b0, 0, 3, 4'd0, 1'b0, 32'h3000_0010, 3'b010, 32'hA0);

    // LSU-only byte load
    bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h0F00_0003; bus.lsu_size_i = 3'd0;
    #1;
    txn(1'b1, 0, 0, 4'd1, 1'b0, 32'h0F00_0003, 3'd0, 32'h55);

    // both held: four LSU wins, then the IFU, twice
    order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h0000_0100;
    bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h0000_0200; bus.lsu_size_i = 3'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (order[i]) txn(1'b1, 0, 0, 4'd1, 1'b1, 32'h0000_0200, 3'd2, 32'h1000 + 32'(i * 16));
      else          txn(1'b0, 0, 3, 4'd0, 1'b1, 32'h0000_0100, 3'b010, 32'h1000 + 32'(i * 16));
    end
    bus.ifu_req_i = 1'b0;
    bus.lsu_req_i = 1'b0;

    // delayed arready with an IFU request waiting throughout
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h4000_0040;
    bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h0F00_0008; bus.lsu_size_i = 3'd2;
    #1;
    txn(1'b1, 5, 0, 4'd1, 1'b0, 32'h0F00_0008, 3'd2, 32'h77);
    #1;
    txn(1'b0, 0, 3, 4'd0, 1'b0, 32'h4000_0040, 3'b010, 32'hB0);

    // early rlast on IFU beat 2, then LSU answer carrying the IFU ID
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h3000_0020;
    #1;
    txn(1'b0, 0, 1, 4'd0, 1'b0, 32'h3000_0020, 3'b010, 32'hC0);
    bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h0F00_0010; bus.lsu_size_i = 3'd1;
    #1;
    txn(1'b1, 0, 0, 4'd0, 1'b0, 32'h0F00_0010, 3'd1, 32'hD0);

    // reset during beat 2 of an IFU burst
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h3000_0030;
    #1;
    check("rb_ifu_gnt", {31'b0, bus.ifu_gnt_o}, 32'd1);
    step();
    bus.ifu_req_i = 1'b0;
    bus.axi_arready_i = 1'b1;
    step();
    bus.axi_arready_i = 1'b0;
    bus.axi_rvalid_i = 1'b1; bus.axi_rdata_i = 32'hE0; bus.axi_rid_i = 4'd0; bus.axi_rlast_i = 1'b0;
    step();
    bus.axi_rdata_i = 32'hE1;
    #1;
    check("rb_beat2_rvalid", {31'b0, bus.ifu_rvalid_o}, 32'd1);
    rst = 1'b1;
    bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h0F00_0020; bus.lsu_size_i = 3'd2;
    #1;
    check("rb_ifu_rvalid", {31'b0, bus.ifu_rvalid_o}, 32'd0);
    check("rb_rsp_data", bus.rsp_data_o, 32'd0);
    check("rb_rready", {31'b0, bus.axi_rready_o}, 32'd0);
    check("rb_lsu_gnt", {31'b0, bus.lsu_gnt_o}, 32'd0);
    step();
    step();
    bus.axi_rvalid_i = 1'b0;
    rst = 1'b0;
    #1;
    txn(1'b1, 0, 0, 4'd1, 1'b0, 32'h0F00_0020, 3'd2, 32'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_rd_arbiter.md
# ysyx_23060025_rd_arbiter

Read-channel arbiter that shares the core's single AXI4 master read path between the IFU (fixed-length INCR burst refills) and the LSU (single-beat loads). It sits between the fetch/load units and the xbar read port. It issues one outstanding transaction at a time, prevents IFU starvation, and checks response framing. Writes bypass this block.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- BURST_LEN, 4, beats per IFU burst (power of two, 1..16)
- STARVE_MAX, 4, consecutive LSU grants tolerated while IFU waits
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ifu_req_i  in  1  IFU read request, held until granted
- ifu_addr_i  in  ADDR_LEN  IFU burst start address, burst-aligned by requester
- ifu_gnt_o  out  1  one-cycle grant pulse; addr captured this cycle
- ifu_rvalid_o  out  1  response beat for IFU
- lsu_req_i  in  1  LSU read request, held until granted
- lsu_addr_i  in  ADDR_LEN  LSU load address
- lsu_size_i  in  3  AXI size code (0/1/2)
- lsu_gnt_o  out  1  one-cycle grant pulse
- lsu_rvalid_o  out  1  response beat for LSU
- rsp_data_o  out  DATA_LEN  shared response data
- rsp_resp_o  out  2  shared response status, 2'b10 on framing/ID error
- rsp_last_o  out  1  final beat of transaction
- axi_arvalid_o / axi_arready_i  out/in  1  AR handshake
- axi_araddr_o  out  ADDR_LEN  AR address
- axi_arid_o  out  4  0 = IFU, 1 = LSU
- axi_arlen_o  out  8  BURST_LEN-1 (IFU), 0 (LSU)
- axi_arsize_o  out  3  3'b010 (IFU), latched lsu_size_i (LSU)
- axi_arburst_o  out  2  always 2'b01 INCR
- axi_rvalid_i / axi_rready_o  in/out  1  R handshake
- axi_rdata_i  in  DATA_LEN  read data
- axi_rresp_i  in  2  read status
- axi_rlast_i  in  1  last beat
- axi_rid_i  in  4  response ID

## Operation
- FSM IDLE -> AR -> R -> IDLE. One transaction outstanding at all times.
- IDLE: if any request, pick an owner, pulse its gnt_o combinationally, latch owner/addr/size/expected len, and go to AR.
  - Priority: LSU wins ties unless starve_cnt == STARVE_MAX, then IFU wins.
  - starve_cnt: +1 (saturating) when LSU is granted while ifu_req_i=1; cleared when IFU is granted.
- AR: arvalid_o=1 with latched fields, held stable until arready_i. On handshake go to R. AR outputs are 0 outside AR.
- R: rready_o=1. On each rvalid_i:
  - owner's rvalid_o=1; rsp_data_o=rdata_i; rsp_resp_o=rresp_i; rsp_last_o=rlast_i (combinational pass-through).
  - beat_cnt increments, saturating at 15.
- Error forcing: rsp_resp_o is forced to 2'b10 on any beat where rid_i != latched ID. It is also forced on the rlast beat if beat_cnt != expected len, and on any beat beyond the expected len.
- Transaction ends only on rvalid_i && rlast_i, then return to IDLE. Requesters never backpressure.

## Timing
- Reset (async assert, sync-clocked release): state IDLE, starve_cnt=0, beat_cnt=0, all outputs 0.
- Reset mid-transaction abandons it immediately. The AXI slave is reset by the same signal.
- Request in IDLE at cycle N: gnt at N, arvalid from N+1. With arready at N+1, the earliest beat is at N+2, which is also the earliest rvalid_o.
- After the last beat, IDLE at the next edge. The minimum gap between consecutive AR handshakes is 2 cycles plus one beat.
- A request arriving during AR/R waits. Both requests pending at IDLE resolve in one cycle, with no gnt on the loser.

## Test plan
- IFU only, addr 0x3000_0010, BURST_LEN=4, arready immediate, beats 0xA0..0xA3 with rlast on the 4th -> arlen=3, arid=0, four ifu_rvalid_o, rsp_last_o on beat 4, resp 0.
- LSU only, addr 0x0F00_0003, size 0 -> arlen=0, arsize=0, arid=1, one lsu_rvalid_o with rsp_last_o=1.
- Both held continuously, STARVE_MAX=4 -> grant order L,L,L,L,I,L,L,L,L,I; starve_cnt resets after each IFU grant.
- arready delayed 5 cycles -> arvalid_o and all AR fields stable for 6 cycles; no grant issued meanwhile.
- IFU burst with rlast on beat 2 -> beat 2 resp forced 2'b10, return to IDLE. Separately, LSU response with rid=0 -> resp 2'b10.
- Reset asserted during beat 2 of an IFU burst -> all outputs 0 asynchronously; a fresh LSU request after release is granted normally.
